// File: rtl/sum_window_accumulator_pkg.sv
// sum_acc_pkg: shared types and helpers for the sum window accumulator
package sum_acc_pkg;

  localparam int DEF_DATA_W = 5;
  localparam int MAX_WIN    = 16;
  localparam int RES_SUM_W  = DEF_DATA_W + $clog2(MAX_WIN);
  localparam int RES_CNT_W  = $clog2(MAX_WIN + 1);

  typedef enum logic [1:0] {
    ACC,
    HOLD,
    STALL
  } state_t;

  // Result record sized for the widest legal window, for sinks and scoreboards.
  typedef struct packed {
    logic [RES_SUM_W-1:0]  sum;
    logic [DEF_DATA_W-1:0] min;
    logic [DEF_DATA_W-1:0] max;
    logic [RES_CNT_W-1:0]  count;
  } result_t;

  function automatic logic [DEF_DATA_W-1:0] min2(input logic [DEF_DATA_W-1:0] a,
                                                 input logic [DEF_DATA_W-1:0] b);
    return (a < b) ? a : b;
  endfunction

  function automatic logic [DEF_DATA_W-1:0] max2(input logic [DEF_DATA_W-1:0] a,
                                                 input logic [DEF_DATA_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sum_window_accumulator_minmax_tracker.sv
// minmax_tracker: running minimum/maximum of the current window
module minmax_tracker
  import sum_acc_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_clr,
  input  logic              i_upd,
  input  logic [DATA_W-1:0] i_data,
  output logic [DATA_W-1:0] o_min,
  output logic [DATA_W-1:0] o_max
);

  logic [DATA_W-1:0] r_min;
  logic [DATA_W-1:0] r_max;

  // Outputs already include this cycle's sample so a completing window sees it.
  assign o_min = i_upd ? min2(r_min, i_data) : r_min;
  assign o_max = i_upd ? max2(r_max, i_data) : r_max;

  // Clear wins over update: the sample that closes a window is already in o_min/o_max.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_min <= '1;
      r_max <= '0;
    end else if (i_clr) begin
      r_min <= '1;
      r_max <= '0;
    end else begin
      r_min <= o_min;
      r_max <= o_max;
    end
  end

endmodule

// File: rtl/sum_window_accumulator.sv
// sum_window_accumulator: windowed total/min/max/count of an incoming sum stream
module sum_window_accumulator
  import sum_acc_pkg::*;
#(
  parameter  int DATA_W = DEF_DATA_W,
  parameter  int WIN    = 4,
  localparam int CNT_W  = $clog2(WIN + 1),
  localparam int SUM_W  = DATA_W + $clog2(WIN)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [SUM_W-1:0]  out_sum,
  output logic [DATA_W-1:0] out_min,
  output logic [DATA_W-1:0] out_max,
  output logic [CNT_W-1:0]  out_count
);

  state_t            r_state;
  state_t            w_state_nx;
  logic [SUM_W-1:0]  r_acc;
  logic [SUM_W-1:0]  w_acc_inc;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_inc;
  logic [CNT_W-1:0]  w_cnt_nx;
  logic              r_flush_pend;
  logic              w_accept;
  logic              w_free;
  logic              w_full;
  logic              w_flush_req;
  logic              w_load;
  logic              w_ov_nx;
  logic [DATA_W-1:0] w_min;
  logic [DATA_W-1:0] w_max;

  // Handshakes come straight from the state register; no path from out_ready.
  assign out_valid = (r_state != ACC);
  assign in_ready  = (r_state != STALL);

  minmax_tracker #(.DATA_W(DATA_W)) u_minmax (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_clr  (w_load),
    .i_upd  (w_accept),
    .i_data (in_data),
    .o_min  (w_min),
    .o_max  (w_max)
  );

  // Datapath next values, result-load decision and next state.
  always_comb begin
    w_state_nx  = r_state;
    w_accept    = in_valid && in_ready;
    w_free      = !out_valid || out_ready;
    w_acc_inc   = r_acc + (w_accept ? SUM_W'(in_data) : '0);
    w_cnt_inc   = r_cnt + CNT_W'(w_accept);
    w_full      = w_accept && (w_cnt_inc == CNT_W'(WIN));
    w_flush_req = flush && ((r_cnt != '0) || w_accept);
    w_load      = w_free && (w_full || w_flush_req || r_flush_pend);
    w_cnt_nx    = w_load ? '0 : w_cnt_inc;
    w_ov_nx     = w_load || (out_valid && !out_ready);
    w_state_nx  = !w_ov_nx ? ACC : (w_cnt_nx == CNT_W'(WIN - 1)) ? STALL : HOLD;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ACC;
    else        r_state <= w_state_nx;
  end

  // Accumulator, sample counter and deferred flush; a load consumes any flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc        <= '0;
      r_cnt        <= '0;
      r_flush_pend <= 1'b0;
    end else begin
      r_acc        <= w_load ? '0 : w_acc_inc;
      r_cnt        <= w_cnt_nx;
      r_flush_pend <= !w_load && (r_flush_pend || w_flush_req);
    end
  end

  // Output registers load with values that include this cycle's sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_sum   <= '0;
      out_min   <= '0;
      out_max   <= '0;
      out_count <= '0;
    end else if (w_load) begin
      out_sum   <= w_acc_inc;
      out_min   <= w_min;
      out_max   <= w_max;
      out_count <= w_cnt_inc;
    end
  end

endmodule

// File: tb/tb_sum_window_accumulator.sv
// tb_sum_window_accumulator: scoreboard bench for the window accumulator
module tb_sum_window_accumulator;
  import sum_acc_pkg::*;

  localparam int DW  = 5;
  localparam int WIN = 4;
  localparam int CW  = $clog2(WIN + 1);
  localparam int SW  = DW + $clog2(WIN);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic          flush = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [SW-1:0] out_sum;
  logic [DW-1:0] out_min;
  logic [DW-1:0] out_max;
  logic [CW-1:0] out_count;

  int      checks = 0;
  int      errors = 0;
  bit      rnd_ready = 1'b0;
  result_t sb[$];
  result_t mon_act;
  result_t mon_exp;

  always #5 clk = ~clk;

  sum_window_accumulator #(.DATA_W(DW), .WIN(WIN)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_min   (out_min),
    .out_max   (out_max),
    .out_count (out_count)
  );

  function automatic result_t mk(input int s, input int mn, input int mx, input int c);
    result_t r;
    r.sum   = RES_SUM_W'(s);
    r.min   = DEF_DATA_W'(mn);
    r.max   = DEF_DATA_W'(mx);
    r.count = RES_CNT_W'(c);
    return r;
  endfunction

  // Every result handed over at the coming edge is checked against the scoreboard.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      mon_act = mk(int'(out_sum), int'(out_min), int'(out_max), int'(out_count));
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL result_unexpected got sum=%0d min=%0d max=%0d count=%0d, required no result",
                 mon_act.sum, mon_act.min, mon_act.max, mon_act.count);
      end else begin
        mon_exp = sb.pop_front();
        if (mon_act !== mon_exp) begin
          errors++;
          $display("FAIL result got sum=%0d min=%0d max=%0d count=%0d, required sum=%0d min=%0d max=%0d count=%0d",
                   mon_act.sum, mon_act.min, mon_act.max, mon_act.count,
                   mon_exp.sum, mon_exp.min, mon_exp.max, mon_exp.count);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Offers one sample (optionally with flush) and returns one edge after it is taken.
  task automatic send(input logic [DW-1:0] d, input bit f = 1'b0);
    if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
    in_valid = 1'b1;
    in_data  = d;
    flush    = f;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (in_ready) begin
        cyc();
        in_valid = 1'b0;
        flush    = 1'b0;
        return;
      end
      cyc();
      if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
    end
    checks++;
    errors++;
    $display("FAIL send_timeout in_ready stayed 0, required 1 within 50 cycles");
    in_valid = 1'b0;
    flush    = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({in_ready, out_valid} !== 2'b10) begin
      errors++;
      $display("FAIL reset_handshake got in_ready=%b out_valid=%b, required 1 0", in_ready, out_valid);
    end
    checks++;
    if ({out_sum, out_min, out_max, out_count} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got sum=%0d min=%0d max=%0d count=%0d, required all 0",
               out_sum, out_min, out_max, out_count);
    end
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic test_basic();
    out_ready = 1'b1;
    sb.push_back(mk(53, 4, 30, 4));
    send(4); send(11); send(8); send(30);
    checks++;
    if (!(out_valid === 1'b1 && out_sum === SW'(53) && out_count === CW'(4))) begin
      errors++;
      $display("FAIL basic_latency got valid=%b sum=%0d count=%0d, required 1 53 4", out_valid, out_sum, out_count);
    end
    cyc();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_one_cycle got out_valid=%b, required 0", out_valid);
    end
  endtask

  task automatic test_stall();
    out_ready = 1'b1;
    sb.push_back(mk(40, 10, 10, 4));
    repeat (4) send(10);
    out_ready = 1'b0;
    sb.push_back(mk(10, 1, 4, 4));
    send(1); send(2); send(3);
    in_valid = 1'b1;
    in_data  = 4;
    @(negedge clk);
    checks++;
    if (!(in_ready === 1'b0 && out_valid === 1'b1 && out_sum === SW'(40))) begin
      errors++;
      $display("FAIL stall_hold got in_ready=%b valid=%b sum=%0d, required 0 1 40", in_ready, out_valid, out_sum);
    end
    cyc();
    out_ready = 1'b1;
    cyc();
    checks++;
    if (!(out_valid === 1'b0 && in_ready === 1'b1)) begin
      errors++;
      $display("FAIL stall_release got valid=%b in_ready=%b, required 0 1", out_valid, in_ready);
    end
    cyc();
    in_valid = 1'b0;
    checks++;
    if (!(out_valid === 1'b1 && out_sum === SW'(10) && out_count === CW'(4))) begin
      errors++;
      $display("FAIL stall_next got valid=%b sum=%0d count=%0d, required 1 10 4", out_valid, out_sum, out_count);
    end
    cyc();
  endtask

  task automatic test_flush();
    out_ready = 1'b1;
    sb.push_back(mk(16, 7, 9, 2));
    send(7); send(9);
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    checks++;
    if (!(out_valid === 1'b1 && out_sum === SW'(16) && out_count === CW'(2))) begin
      errors++;
      $display("FAIL flush_partial got valid=%b sum=%0d count=%0d, required 1 16 2", out_valid, out_sum, out_count);
    end
    sb.push_back(mk(4, 1, 1, 4));
    repeat (4) send(1);
    cyc();
  endtask

  task automatic test_flush_edges();
    out_ready = 1'b1;
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_empty got out_valid=%b, required 0", out_valid);
    end
    sb.push_back(mk(8, 2, 2, 4));
    repeat (4) send(2);
    sb.push_back(mk(12, 3, 3, 4));
    send(3); send(3); send(3); send(3, 1'b1);
    checks++;
    if (!(out_valid === 1'b1 && out_count === CW'(4))) begin
      errors++;
      $display("FAIL flush_on_full got valid=%b count=%0d, required 1 4", out_valid, out_count);
    end
    cyc();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_on_full_single got out_valid=%b, required 0", out_valid);
    end
  endtask

  task automatic test_pend();
    out_ready = 1'b0;
    sb.push_back(mk(24, 6, 6, 4));
    repeat (4) send(6);
    send(5);
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    checks++;
    if (dut.r_flush_pend !== 1'b1) begin
      errors++;
      $display("FAIL pend_set got flush_pend=%b, required 1", dut.r_flush_pend);
    end
    cyc(); cyc();
    checks++;
    if (!(out_valid === 1'b1 && out_sum === SW'(24) && out_count === CW'(4))) begin
      errors++;
      $display("FAIL pend_hold got valid=%b sum=%0d count=%0d, required 1 24 4", out_valid, out_sum, out_count);
    end
    sb.push_back(mk(5, 5, 5, 1));
    out_ready = 1'b1;
    cyc();
    checks++;
    if (!(out_valid === 1'b1 && out_sum === SW'(5) && out_count === CW'(1))) begin
      errors++;
      $display("FAIL pend_emit got valid=%b sum=%0d count=%0d, required 1 5 1", out_valid, out_sum, out_count);
    end
    cyc();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL pend_done got out_valid=%b, required 0", out_valid);
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1;
    send(9); send(9);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({in_ready, out_valid, out_sum, out_min, out_max, out_count} !== {1'b1, 1'b0, {(SW + 2 * DW + CW){1'b0}}}) begin
      errors++;
      $display("FAIL reset_mid got in_ready=%b valid=%b sum=%0d min=%0d max=%0d count=%0d, required 1 0 0 0 0 0",
               in_ready, out_valid, out_sum, out_min, out_max, out_count);
    end
    @(negedge clk);
    rst_n = 1'b1;
    cyc();
    sb.push_back(mk(20, 5, 5, 4));
    repeat (4) send(5);
    cyc();
  endtask

  task automatic test_back_to_back();
    int s = 0;
    int mn = 31;
    int mx = 0;
    int c = 0;
    int d;
    rnd_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      d  = $urandom_range(0, 30);
      s  += d;
      mn = (d < mn) ? d : mn;
      mx = (d > mx) ? d : mx;
      c++;
      if (c == WIN) begin
        sb.push_back(mk(s, mn, mx, c));
        s = 0; mn = 31; mx = 0; c = 0;
      end
      send(DW'(d));
    end
    rnd_ready = 1'b0;
    out_ready = 1'b1;
    repeat (6) cyc();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d results outstanding, required 0", sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_flush();
    test_flush_edges();
    test_pend();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
